// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: STAGES-deep valid/ready register chain with stall, flush and bubbles.
// Optional perf counters (bubble_cnt, kill_cnt) with `define PIPE_STAGE_PERF_CNT_EN.
module pipe_stage_chain #(
  parameter int DATA_W = 64,
  parameter int STAGES = 4
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic                         enable,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         in_ready,
  input  logic [STAGES-1:0]            stall,
  input  logic [STAGES-1:0]            flush,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  input  logic                         out_ready,
  output logic                         out_fire,
  output logic [$clog2(STAGES+1)-1:0]  occupancy
`ifdef PIPE_STAGE_PERF_CNT_EN
  ,
  output logic [31:0]                  bubble_cnt,
  output logic [31:0]                  kill_cnt
`endif
);

  localparam int OW = $clog2(STAGES+1);
  localparam int L  = STAGES-1;

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] ev;
  logic [STAGES-1:0] fl;
  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] inc;
  logic [DATA_W-1:0] d  [STAGES];
  logic [DATA_W-1:0] up [STAGES];

  // flush is ignored while frozen, so a disabled chain shows its true state
  assign fl = flush & {STAGES{enable}};
  assign ev = v & ~fl;

  always_comb begin : hold_chain
    logic [STAGES-1:0] h;
    h    = '0;
    h[L] = ev[L] & (stall[L] | ~out_ready);
    for (int k = L-1; k >= 0; k--)
      h[k] = ev[k] & (stall[k] | h[k+1]);
    hold = h;
  end

  assign in_ready  = enable & ~hold[0];
  assign out_valid = ev[L];
  assign out_data  = d[L];
  assign out_fire  = enable & ev[L] & ~hold[L];

  always_comb begin
    inc    = '0;
    inc[0] = in_valid & in_ready;
    up[0]  = in_data;
    for (int k = 1; k < STAGES; k++) begin
      inc[k] = ev[k-1] & ~hold[k-1];
      up[k]  = d[k-1];
    end
  end

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < STAGES; k++)
      occupancy = occupancy + OW'(v[k]);
  end

  // inc[k] and hold[k] are mutually exclusive, so a load never hits a held stage
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      v <= '0;
      for (int k = 0; k < STAGES; k++)
        d[k] <= '0;
    end else if (enable) begin
      for (int k = 0; k < STAGES; k++) begin
        v[k] <= hold[k] ? ev[k] : inc[k];
        if (inc[k])
          d[k] <= up[k];
      end
    end
  end

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [OW-1:0] kills;
  logic [32:0]   ksum;

  always_comb begin
    kills = '0;
    for (int k = 0; k < STAGES; k++)
      kills = kills + OW'(v[k] & fl[k]);
  end

  assign ksum = {1'b0, kill_cnt} + 33'(kills);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      bubble_cnt <= '0;
      kill_cnt   <= '0;
    end else if (enable) begin
      if (!out_valid && bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + 32'd1;
      kill_cnt <= ksum[32] ? '1 : ksum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: vector tables plus an in-order scoreboard for pipe_stage_chain.
// Build with PIPE_STAGE_PERF_CNT_EN to also exercise the perf counters.
module tb_pipe_stage_chain;

  localparam int DW = 64;
  localparam int S  = 4;

  logic          clk;
  logic          arst;
  logic          enable;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [S-1:0]  stall;
  logic [S-1:0]  flush;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          out_fire;
  logic [2:0]    occupancy;
`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [31:0]   bubble_cnt;
  logic [31:0]   kill_cnt;
  logic [31:0]   k0;
`endif

  pipe_stage_chain #(.DATA_W(DW), .STAGES(S)) dut (
    .clk       (clk),
    .arst      (arst),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .stall     (stall),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_fire  (out_fire),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,
    .bubble_cnt(bubble_cnt),
    .kill_cnt  (kill_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk;
  int n_fail;
  logic [DW-1:0] sb [$];

  localparam logic [DW-1:0] A = 64'h0000_0000_0000_00A1;
  localparam logic [DW-1:0] B = 64'h0000_0000_0000_00B2;
  localparam logic [DW-1:0] C = 64'h0000_0000_0000_00C3;
  localparam logic [DW-1:0] D = 64'h0000_0000_0000_00D4;

  typedef struct {
    logic          en;
    logic          iv;
    logic [DW-1:0] din;
    logic          ordy;
    logic [S-1:0]  st;
    logic [S-1:0]  fl;
    logic          eir;
    logic          eov;
    logic [DW-1:0] eod;
    logic          efire;
    logic [2:0]    eocc;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic en, logic iv, logic [DW-1:0] din,
                              logic ordy, logic [S-1:0] st,
                              logic [S-1:0] fl, logic eir, logic eov,
                              logic [DW-1:0] eod, logic efire,
                              logic [2:0] eocc);
    vec_t r;
    r.en = en; r.iv = iv; r.din = din; r.ordy = ordy;
    r.st = st; r.fl = fl; r.eir = eir; r.eov = eov;
    r.eod = eod; r.efire = efire; r.eocc = eocc;
    return r;
  endfunction

  // scoreboard: push on accept, pop and compare on tail transfer
  always @(negedge clk) begin
    if (!arst) begin
      if (out_fire) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_underflow: got %h expected nothing", out_data);
        end else begin
          chk("sb_order", out_data, sb.pop_front());
        end
      end
      if (in_valid && in_ready)
        sb.push_back(in_data);
    end
  end

  task automatic drive(logic en, logic iv, logic [DW-1:0] din,
                       logic ordy, logic [S-1:0] st, logic [S-1:0] fl);
    enable = en; in_valid = iv; in_data = din;
    out_ready = ordy; stall = st; flush = fl;
  endtask

  task automatic run_tbl(input string tag);
    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].iv, tbl[i].din, tbl[i].ordy,
            tbl[i].st, tbl[i].fl);
      @(negedge clk);
      chk($sformatf("%s[%0d].in_ready", tag, i), in_ready, tbl[i].eir);
      chk($sformatf("%s[%0d].out_valid", tag, i), out_valid, tbl[i].eov);
      chk($sformatf("%s[%0d].out_fire", tag, i), out_fire, tbl[i].efire);
      chk($sformatf("%s[%0d].occ", tag, i), occupancy, tbl[i].eocc);
      if (tbl[i].eov)
        chk($sformatf("%s[%0d].out_data", tag, i), out_data, tbl[i].eod);
      @(posedge clk);
      #1;
    end
    tbl.delete();
  endtask

  // leaves D,C,B,A in stages 0..3 with out_ready low
  task automatic fill();
    logic [DW-1:0] vals [4];
    vals[0] = A; vals[1] = B; vals[2] = C; vals[3] = D;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, vals[i], 1'b0, '0, '0);
      @(posedge clk);
      #1;
    end
    drive(1'b1, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    drive(1'b1, 1'b0, '0, 1'b1, '0, '0);
    for (int i = 0; i < 16 && !done; i++) begin
      @(negedge clk);
      if (occupancy == 0) done = 1'b1;
      @(posedge clk);
      #1;
    end
    chk({tag, ".drain_occ"}, occupancy, 3'd0);
    chk({tag, ".sb_left"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    arst = 1'b1;
    drive(1'b1, 1'b0, '0, 1'b1, '0, '0);
    #3;
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.out_fire", out_fire, 1'b0);
    chk("rst.occ", occupancy, 3'd0);
    chk("rst.out_data", out_data, '0);
    chk("rst.in_ready_en1", in_ready, 1'b1);
    enable = 1'b0;
    #1;
    chk("rst.in_ready_en0", in_ready, 1'b0);
    enable = 1'b1;
`ifdef PIPE_STAGE_PERF_CNT_EN
    chk("rst.bubble_cnt", bubble_cnt, '0);
    chk("rst.kill_cnt", kill_cnt, '0);
`endif
    @(posedge clk);
    #1;
    arst = 1'b0;

    // 1: streaming, 4-cycle latency from acceptance to output
    tbl.push_back(mk(1, 1, 64'h11, 1, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 64'h22, 1, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 64'h33, 1, 0, 0, 1, 0, 0, 0, 2));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 3));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 1, 64'h11, 1, 3));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 1, 64'h22, 1, 2));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 1, 64'h33, 1, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
    run_tbl("stream");

    // 2: backpressure then drain while refilling
    fill();
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, A, 0, 4));
    tbl.push_back(mk(1, 1, 64'hEE, 0, 0, 0, 0, 1, A, 0, 4));
    tbl.push_back(mk(1, 1, 64'hE5, 1, 0, 0, 1, 1, A, 1, 4));
    tbl.push_back(mk(1, 1, 64'hF6, 1, 0, 0, 1, 1, B, 1, 4));
    tbl.push_back(mk(1, 1, 64'h07, 1, 0, 0, 1, 1, C, 1, 4));
    tbl.push_back(mk(1, 1, 64'h18, 1, 0, 0, 1, 1, D, 1, 4));
    run_tbl("bp");
    drain("bp");

    // 3: stall stage 1 for two cycles opens a two-cycle bubble
    fill();
    tbl.push_back(mk(1, 0, 0, 1, 4'b0010, 0, 0, 1, A, 1, 4));
    tbl.push_back(mk(1, 0, 0, 1, 4'b0010, 0, 0, 1, B, 1, 3));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 2));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 2));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 1, C, 1, 2));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 1, D, 1, 1));
    run_tbl("stall");
    drain("stall");

    // 4: flush the two youngest entries while the tail is backpressured
    fill();
    void'(sb.pop_back());
    void'(sb.pop_back());
`ifdef PIPE_STAGE_PERF_CNT_EN
    k0 = kill_cnt;
`endif
    tbl.push_back(mk(1, 0, 0, 0, 0, 4'b0011, 1, 1, A, 0, 4));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 1, A, 1, 2));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 1, B, 1, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
    run_tbl("flush");
`ifdef PIPE_STAGE_PERF_CNT_EN
    chk("flush.kill_cnt", kill_cnt, 64'(k0 + 32'd2));
`endif
    drain("flush");

    // 5: flush beats stall on the tail; B refills stage 3 on the same edge
    fill();
    void'(sb.pop_front());
`ifdef PIPE_STAGE_PERF_CNT_EN
    k0 = kill_cnt;
`endif
    tbl.push_back(mk(1, 0, 0, 0, 4'b1000, 4'b1000, 1, 0, 0, 0, 4));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 1, B, 1, 3));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 1, C, 1, 2));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 1, D, 1, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
    run_tbl("fl_st");
`ifdef PIPE_STAGE_PERF_CNT_EN
    chk("fl_st.kill_cnt", kill_cnt, 64'(k0 + 32'd1));
`endif
    drain("fl_st");

    // 6: freeze ignores flush and input, then async reset mid-stream
    fill();
    tbl.push_back(mk(0, 1, 64'h99, 1, 0, 4'b1111, 0, 1, A, 0, 4));
    tbl.push_back(mk(0, 1, 64'h99, 1, 0, 4'b1111, 0, 1, A, 0, 4));
    tbl.push_back(mk(0, 1, 64'h99, 1, 0, 4'b1111, 0, 1, A, 0, 4));
    run_tbl("freeze");
    drive(1'b1, 1'b1, 64'h77, 1'b1, '0, '0);
    @(posedge clk);
    #2;
    chk("pre_rst.occ", occupancy, 3'd4);
    arst = 1'b1;
    #1;
    chk("arst.occ", occupancy, 3'd0);
    chk("arst.out_valid", out_valid, 1'b0);
    chk("arst.out_fire", out_fire, 1'b0);
    chk("arst.in_ready", in_ready, 1'b1);
    sb.delete();
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    arst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst.occ", occupancy, 3'd0);
    chk("post_rst.out_valid", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
